color_histogram: RTL and testbench
==================================

// Module: color_histogram
// PURPOSE
//  Upstream stage of the centroid block. Consumes the QQVGA pixel stream after the color filter
//  (one hit flag per pixel) and counts hits inside the 128x104 inner frame into 8 column bins.
//  At end of frame it latches the total, bin and partial-sum counts that centroid consumes,
//  then pulses new_frame_proc_o.
// PARAMETERS
//  c_img_cols      160  image columns
//  c_img_rows      120  image rows
//  c_inframe_cols  128  inner frame columns; centred, 16 excluded each side
//  c_inframe_rows  104  inner frame rows; centred, 8 excluded top and bottom
//  c_hist_bins       8  column bins; 16 columns per bin
//  c_nb_inframe_pxls $clog2(128*104)=14  width of the total count
//  c_nb_hist_val   $clog2(104*16)=11     width of one bin (max 1664)
// PORTS
//  clk               in   1   fpga clock
//  rst               in   1   reset, synchronous, active high
//  px_valid_i        in   1   pixel present this cycle
//  px_sof_i          in   1   first pixel of frame; only meaningful with px_valid_i
//  px_hit_i          in   1   pixel passed the color filter; only meaningful with px_valid_i
//  colorpxls_o       out  14  total hits in the inner frame
//  colorpxls_bin0_o  out  11  hits in bin 0 (leftmost)
//  colorpxls_bin7_o  out  11  hits in bin 7 (rightmost)
//  colorpxls_left_o  out  13  sum of bins 0..3
//  colorpxls_rght_o  out  13  sum of bins 4..7
//  colorpxls_bin012_o out 13  sum of bins 0..2
//  colorpxls_bin567_o out 13  sum of bins 5..7
//  colorpxls_bin01_o out  13  sum of bins 0..1
//  colorpxls_bin67_o out  13  sum of bins 6..7
//  new_frame_proc_o  out  1   one-cycle pulse: all outputs above updated
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, counters and bins 0.
//  - FSM IDLE -> ACCUM on px_valid_i & px_sof_i. In IDLE, pixels without sof are ignored.
//  - SOF pixel: clear the bins and the row/col counters, then accumulate that pixel at (0,0).
//  - ACCUM, each px_valid_i: col increments; col wraps 159->0 with row+1.
//  - Pixel is inside the inner frame when 16<=col<=143 and 8<=row<=111.
//    Its bin index is (col-16)>>4. If px_hit_i=1, that bin increments by 1.
//  - px_valid_i=0 means a stall: counters and bins hold; gaps of any length are allowed.
//  - Pixel (119,159) accepted in cycle N: ACCUM->SUM; the bins are final in cycle N+1.
//  - SUM (one cycle): adder tree computes the total and partial sums; output registers load
//    at the end of N+1. new_frame_proc_o=1 during N+2 only; next state IDLE.
//  - Outputs hold until the next pulse. Latency from last pixel to pulse is exactly 2 cycles.
//  - px_sof_i in ACCUM (mid-frame): discard the partial frame, restart at (0,0) with this
//    pixel, no pulse. px_sof_i with the last pixel counts as a restart; no pulse.
//  - Pixels arriving in SUM are ignored; a sof arriving in SUM is lost, so upstream
//    guarantees >=1 cycle between frames.
//  - Widths: bins never overflow (max 1664 < 2048); sums zero-extended; no saturation needed.
//  - rst mid-frame: returns to IDLE with outputs cleared; no pulse.
// CONFIGURATION
//  COLOR_HIST_ALLBINS_EN defined: adds output hist_bins_o [8*11-1:0], bin k at [11k+10:11k],
//    registered together with the other outputs (reset 0).
//  Not defined: port absent; bins 1..6 are internal only. All other behaviour is identical.
// STRUCTURE
//  - Shared package/header: image and inner-frame dimensions, inner-frame bounds
//    (16/143, 8/111), c_hist_bins, c_nb_inframe_pxls, c_nb_hist_val, FSM state encoding.
//    centroid uses the same constants.
//  - Sub-module pxl_coord_cnt: row/col counters with sof clear, valid-gated wrap, last-pixel
//    flag, and in_frame / bin index outputs.
//  - Top level: FSM, bin registers, adder tree, output registers.
// TESTING
//  1 rst held for 3 cycles mid-frame -> all outputs 0, no pulse, next full frame counted correctly.
//  2 Full frame, every hit=1 -> colorpxls=13312, bin0=bin7=1664, left=rght=6656,
//    bin012=bin567=4992, bin01=bin67=3328; pulse exactly 2 cycles after the last pixel.
//  3 Hits only at cols 16..31, rows 8..111 -> bin0=1664, left=bin01=bin012=1664,
//    all right-side outputs 0, colorpxls=1664.
//  4 Hits only outside the inner frame (cols 0..15, rows 0..7) -> all counts 0, pulse still issued.
//  5 Second sof at row 50 of a frame, then a full all-hit frame -> exactly one pulse,
//    values as in test 2.
//  6 Test 2 repeated with random px_valid_i gaps (0..5 cycles) -> identical values;
//    with COLOR_HIST_ALLBINS_EN, hist_bins_o = 8 x 1664.

Source files
------------

// File: rtl/color_histogram_pkg.sv
// ============================================================================
// Module      : color_histogram_pkg
// Description : Frame geometry, bin widths and FSM encoding shared by the
//               color histogram and the downstream centroid stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package color_histogram_pkg;

    localparam int c_img_cols        = 160;
    localparam int c_img_rows        = 120;
    localparam int c_inframe_cols    = 128;
    localparam int c_inframe_rows    = 104;
    localparam int c_hist_bins       = 8;
    localparam int c_bin_cols        = c_inframe_cols / c_hist_bins;
    localparam int c_nb_inframe_pxls = $clog2(c_inframe_cols * c_inframe_rows);
    localparam int c_nb_hist_val     = $clog2(c_inframe_rows * c_bin_cols);
    localparam int c_nb_part_sum     = 13;
    localparam int c_nb_col          = $clog2(c_img_cols);
    localparam int c_nb_row          = $clog2(c_img_rows);
    localparam int c_nb_bin_idx      = $clog2(c_hist_bins);

    // Inner-frame bounds (inclusive) and last-pixel coordinates
    localparam logic [c_nb_col-1:0] c_col_lo   = 8'd16;
    localparam logic [c_nb_col-1:0] c_col_hi   = 8'd143;
    localparam logic [c_nb_row-1:0] c_row_lo   = 7'd8;
    localparam logic [c_nb_row-1:0] c_row_hi   = 7'd111;
    localparam logic [c_nb_col-1:0] c_col_last = 8'd159;
    localparam logic [c_nb_row-1:0] c_row_last = 7'd119;

    typedef logic [c_nb_hist_val-1:0]     hist_val_t;
    typedef logic [c_nb_part_sum-1:0]     part_sum_t;
    typedef logic [c_nb_inframe_pxls-1:0] total_t;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_sum   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/color_histogram_if.sv
// ============================================================================
// Module      : color_histogram_if
// Description : Pixel-stream input and histogram result bundle.
//               COLOR_HIST_ALLBINS_EN adds the packed all-bins output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface color_histogram_if;
    import color_histogram_pkg::*;

    logic      px_valid_i;
    logic      px_sof_i;
    logic      px_hit_i;
    total_t    colorpxls_o;
    hist_val_t colorpxls_bin0_o;
    hist_val_t colorpxls_bin7_o;
    part_sum_t colorpxls_left_o;
    part_sum_t colorpxls_rght_o;
    part_sum_t colorpxls_bin012_o;
    part_sum_t colorpxls_bin567_o;
    part_sum_t colorpxls_bin01_o;
    part_sum_t colorpxls_bin67_o;
    logic      new_frame_proc_o;
`ifdef COLOR_HIST_ALLBINS_EN
    logic [c_hist_bins*c_nb_hist_val-1:0] hist_bins_o;
`endif

    modport master (
        output px_valid_i, px_sof_i, px_hit_i,
        input
`ifdef COLOR_HIST_ALLBINS_EN
              hist_bins_o,
`endif
              colorpxls_o, colorpxls_bin0_o, colorpxls_bin7_o,
              colorpxls_left_o, colorpxls_rght_o, colorpxls_bin012_o,
              colorpxls_bin567_o, colorpxls_bin01_o, colorpxls_bin67_o,
              new_frame_proc_o
    );

    modport slave (
        input  px_valid_i, px_sof_i, px_hit_i,
        output
`ifdef COLOR_HIST_ALLBINS_EN
               hist_bins_o,
`endif
               colorpxls_o, colorpxls_bin0_o, colorpxls_bin7_o,
               colorpxls_left_o, colorpxls_rght_o, colorpxls_bin012_o,
               colorpxls_bin567_o, colorpxls_bin01_o, colorpxls_bin67_o,
               new_frame_proc_o
    );

endinterface

`default_nettype wire

// File: rtl/color_histogram_pxl_coord_cnt.sv
// ============================================================================
// Module      : color_histogram_pxl_coord_cnt
// Description : Row/column tracker for the pixel stream; flags the last pixel
//               and reports inner-frame membership and column bin index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_histogram_pxl_coord_cnt
    import color_histogram_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_advance,
    input  wire logic                    i_sof,
    output logic                         o_last,
    output logic                         o_in_frame,
    output logic [c_nb_bin_idx-1:0]      o_bin_idx
);

    localparam logic [c_nb_col-1:0]   c_col_one = 1;
    localparam logic [c_nb_row-1:0]   c_row_one = 1;
    localparam logic [c_nb_col-5:0]   c_blk_one = 1;

    // r_row/r_col hold the coordinate the next accepted pixel will have
    logic [c_nb_row-1:0] r_row;
    logic [c_nb_col-1:0] r_col;
    logic [c_nb_row-1:0] w_row;
    logic [c_nb_col-1:0] w_col;
    logic [c_nb_col-5:0] w_col_bin;
    logic                w_row_in;

    assign w_row = i_sof ? '0 : r_row;
    assign w_col = i_sof ? '0 : r_col;

    // Columns 16..143 map to 16-column blocks 1..8; minus one gives the bin,
    // and the top bit of the result is set exactly when the column is outside.
    assign w_col_bin  = w_col[c_nb_col-1:4] - c_blk_one;
    assign w_row_in   = (w_row >= c_row_lo) && (w_row <= c_row_hi);
    assign o_in_frame = w_row_in && !w_col_bin[c_nb_col-5];
    assign o_bin_idx  = w_col_bin[c_nb_bin_idx-1:0];
    assign o_last     = (w_row == c_row_last) && (w_col == c_col_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col == c_col_last) begin
                r_col <= '0;
                r_row <= (w_row == c_row_last) ? '0 : w_row + c_row_one;
            end else begin
                r_col <= w_col + c_col_one;
                r_row <= w_row;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/color_histogram.sv
// ============================================================================
// Module      : color_histogram
// Description : Counts color-filter hits in the inner frame into 8 column bins
//               and publishes totals/partial sums at end of frame.
//               COLOR_HIST_ALLBINS_EN exports all bins on hist_bins_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_histogram
    import color_histogram_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    color_histogram_if.slave  hist
);

    logic [1:0]              r_state;
    hist_val_t               r_bins [c_hist_bins];
    logic                    w_accept;
    logic                    w_last;
    logic                    w_in_frame;
    logic [c_nb_bin_idx-1:0] w_bin_idx;
    logic [c_hist_bins-1:0]  w_hit_inc;

    // SUM accepts nothing; IDLE only wakes up on a start-of-frame pixel
    assign w_accept = hist.px_valid_i &
                      (((r_state == c_st_idle) & hist.px_sof_i) | (r_state == c_st_accum));
    assign w_hit_inc = (hist.px_hit_i && w_in_frame) ?
                       ({{(c_hist_bins-1){1'b0}}, 1'b1} << w_bin_idx) : '0;

    color_histogram_pxl_coord_cnt u_pxl_coord_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_advance  (w_accept),
        .i_sof      (hist.px_sof_i),
        .o_last     (w_last),
        .o_in_frame (w_in_frame),
        .o_bin_idx  (w_bin_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (w_accept) r_state <= c_st_accum;
                c_st_accum: if (w_accept && w_last) r_state <= c_st_sum;
                c_st_sum:   r_state <= c_st_idle;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < c_hist_bins; k++) begin
            if (rst)
                r_bins[k] <= '0;
            else if (w_accept)
                r_bins[k] <= (hist.px_sof_i ? '0 : r_bins[k]) + hist_val_t'(w_hit_inc[k]);
        end
    end

    part_sum_t w_bin01, w_bin012, w_left;
    part_sum_t w_bin67, w_bin567, w_rght;
    total_t    w_total;

    assign w_bin01  = part_sum_t'(r_bins[0]) + part_sum_t'(r_bins[1]);
    assign w_bin012 = w_bin01 + part_sum_t'(r_bins[2]);
    assign w_left   = w_bin012 + part_sum_t'(r_bins[3]);
    assign w_bin67  = part_sum_t'(r_bins[6]) + part_sum_t'(r_bins[7]);
    assign w_bin567 = w_bin67 + part_sum_t'(r_bins[5]);
    assign w_rght   = w_bin567 + part_sum_t'(r_bins[4]);
    assign w_total  = total_t'(w_left) + total_t'(w_rght);

    total_t    r_total;
    hist_val_t r_bin0, r_bin7;
    part_sum_t r_left, r_rght, r_bin012, r_bin567, r_bin01, r_bin67;
    logic      r_new_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total     <= '0;
            r_bin0      <= '0;
            r_bin7      <= '0;
            r_left      <= '0;
            r_rght      <= '0;
            r_bin012    <= '0;
            r_bin567    <= '0;
            r_bin01     <= '0;
            r_bin67     <= '0;
            r_new_frame <= 1'b0;
        end else begin
            r_new_frame <= (r_state == c_st_sum);
            if (r_state == c_st_sum) begin
                r_total  <= w_total;
                r_bin0   <= r_bins[0];
                r_bin7   <= r_bins[7];
                r_left   <= w_left;
                r_rght   <= w_rght;
                r_bin012 <= w_bin012;
                r_bin567 <= w_bin567;
                r_bin01  <= w_bin01;
                r_bin67  <= w_bin67;
            end
        end
    end

    assign hist.colorpxls_o        = r_total;
    assign hist.colorpxls_bin0_o   = r_bin0;
    assign hist.colorpxls_bin7_o   = r_bin7;
    assign hist.colorpxls_left_o   = r_left;
    assign hist.colorpxls_rght_o   = r_rght;
    assign hist.colorpxls_bin012_o = r_bin012;
    assign hist.colorpxls_bin567_o = r_bin567;
    assign hist.colorpxls_bin01_o  = r_bin01;
    assign hist.colorpxls_bin67_o  = r_bin67;
    assign hist.new_frame_proc_o   = r_new_frame;

`ifdef COLOR_HIST_ALLBINS_EN
    logic [c_hist_bins*c_nb_hist_val-1:0] r_hist_bins;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_bins <= '0;
        end else if (r_state == c_st_sum) begin
            for (int k = 0; k < c_hist_bins; k++)
                r_hist_bins[k*c_nb_hist_val +: c_nb_hist_val] <= r_bins[k];
        end
    end

    assign hist.hist_bins_o = r_hist_bins;
`endif

endmodule

`default_nettype wire

// File: tb/tb_color_histogram.sv
// ============================================================================
// Module      : tb_color_histogram
// Description : Self-checking bench for color_histogram against a per-frame
//               bin-count model of the pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_color_histogram;
    import color_histogram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    color_histogram_if hif ();

    color_histogram dut (
        .clk  (clk),
        .rst  (rst),
        .hist (hif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state: written by the driver only
    int mdl_bins [8];
    int pend     [8];
    bit mdl_active = 1'b0;
    int pulse_due  = -1;

    // Expected published values: written by the compare process only
    int exp_bins [8];
    int dut_pulses = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int bsum(input int lo, input int hi);
        int s = 0;
        for (int k = lo; k <= hi; k++) s += exp_bins[k];
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) exp_bins[k] = 0;
        end else begin
            bit exp_p;
            exp_p = (cyc == pulse_due);
            if (exp_p)
                for (int k = 0; k < 8; k++) exp_bins[k] = pend[k];
            chk("pulse", int'(hif.new_frame_proc_o), int'(exp_p));
            if (hif.new_frame_proc_o) dut_pulses++;
            chk("colorpxls", int'(hif.colorpxls_o), bsum(0, 7));
            chk("bin0",      int'(hif.colorpxls_bin0_o), exp_bins[0]);
            chk("bin7",      int'(hif.colorpxls_bin7_o), exp_bins[7]);
            chk("left",      int'(hif.colorpxls_left_o), bsum(0, 3));
            chk("rght",      int'(hif.colorpxls_rght_o), bsum(4, 7));
            chk("bin012",    int'(hif.colorpxls_bin012_o), bsum(0, 2));
            chk("bin567",    int'(hif.colorpxls_bin567_o), bsum(5, 7));
            chk("bin01",     int'(hif.colorpxls_bin01_o), bsum(0, 1));
            chk("bin67",     int'(hif.colorpxls_bin67_o), bsum(6, 7));
`ifdef COLOR_HIST_ALLBINS_EN
            for (int k = 0; k < 8; k++)
                chk($sformatf("hist_bins[%0d]", k), int'(hif.hist_bins_o[k*11 +: 11]), exp_bins[k]);
`endif
        end
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
        hif.px_valid_i = 1'b0;
        hif.px_sof_i   = 1'($urandom_range(0, 1));
        hif.px_hit_i   = 1'($urandom_range(0, 1));
    endtask

    task automatic send_px(input bit sof, input bit hit, input int row, input int col);
        @(posedge clk); #1;
        hif.px_valid_i = 1'b1;
        hif.px_sof_i   = sof;
        hif.px_hit_i   = hit;
        if (sof) begin
            for (int k = 0; k < 8; k++) mdl_bins[k] = 0;
            mdl_active = 1'b1;
        end
        if (mdl_active) begin
            if (hit && row >= 8 && row <= 111 && col >= 16 && col <= 143)
                mdl_bins[(col - 16) / 16]++;
            if (!sof && row == 119 && col == 159) begin
                for (int k = 0; k < 8; k++) pend[k] = mdl_bins[k];
                pulse_due  = cyc + 2;
                mdl_active = 1'b0;
            end
        end
    endtask

    // pattern: 0 all hits, 1 bin-0 column band only, 2 random outside inner frame, 3 random
    function automatic bit pick_hit(input int pattern, input int r, input int c);
        bit inner;
        inner = (r >= 8 && r <= 111 && c >= 16 && c <= 143);
        case (pattern)
            0:       return 1'b1;
            1:       return (c >= 16 && c <= 31 && r >= 8 && r <= 111);
            2:       return inner ? 1'b0 : 1'($urandom_range(0, 1));
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic send_frame(input int pattern, input bit gaps, input int stop_row);
        for (int r = 0; r < 120; r++) begin
            if (r == stop_row) return;
            for (int c = 0; c < 160; c++) begin
                if (gaps && $urandom_range(0, 31) == 0)
                    repeat ($urandom_range(0, 5)) idle_cycle();
                send_px(r == 0 && c == 0, pick_hit(pattern, r, c), r, c);
            end
        end
    endtask

    task automatic finish_frame(input int pulses_before, input string name);
        repeat (5) idle_cycle();
        chk({name, "_pulse_count"}, dut_pulses - pulses_before, 1);
    endtask

    task automatic lit(input string name, input int t, input int b0, input int b7,
                       input int l, input int rg, input int b012, input int b567,
                       input int b01, input int b67);
        chk({name, "_colorpxls"}, int'(hif.colorpxls_o), t);
        chk({name, "_bin0"},      int'(hif.colorpxls_bin0_o), b0);
        chk({name, "_bin7"},      int'(hif.colorpxls_bin7_o), b7);
        chk({name, "_left"},      int'(hif.colorpxls_left_o), l);
        chk({name, "_rght"},      int'(hif.colorpxls_rght_o), rg);
        chk({name, "_bin012"},    int'(hif.colorpxls_bin012_o), b012);
        chk({name, "_bin567"},    int'(hif.colorpxls_bin567_o), b567);
        chk({name, "_bin01"},     int'(hif.colorpxls_bin01_o), b01);
        chk({name, "_bin67"},     int'(hif.colorpxls_bin67_o), b67);
    endtask

    initial begin
        int p0;
        hif.px_valid_i = 1'b0;
        hif.px_sof_i   = 1'b0;
        hif.px_hit_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        lit("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_pulse", int'(hif.new_frame_proc_o), 0);

        // Stray pixels without sof while idle are ignored
        for (int i = 0; i < 6; i++) send_px(1'b0, 1'b1, 119, 159);
        idle_cycle();

        // Reset held 3 cycles in the middle of a frame
        p0 = dut_pulses;
        send_frame(3, 1'b0, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        hif.px_valid_i = 1'b0;
        pulse_due  = -1;
        mdl_active = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        lit("midreset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midreset_no_pulse", dut_pulses - p0, 0);

        // Full all-hit frame
        p0 = dut_pulses;
        send_frame(0, 1'b0, -1);
        finish_frame(p0, "allhit");
        lit("allhit", 13312, 1664, 1664, 6656, 6656, 4992, 4992, 3328, 3328);

        // Hits confined to the bin-0 column band
        p0 = dut_pulses;
        send_frame(1, 1'b0, -1);
        finish_frame(p0, "bin0");
        lit("bin0", 1664, 1664, 0, 1664, 0, 1664, 0, 1664, 0);

        // Hits only outside the inner frame
        p0 = dut_pulses;
        send_frame(2, 1'b0, -1);
        finish_frame(p0, "outside");
        lit("outside", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-frame sof at row 50, then an all-hit frame with random stalls
        p0 = dut_pulses;
        send_frame(3, 1'b0, 50);
        send_frame(0, 1'b1, -1);
        finish_frame(p0, "restart_gaps");
        lit("restart_gaps", 13312, 1664, 1664, 6656, 6656, 4992, 4992, 3328, 3328);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
